// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits are served combinationally
// in IDLE; a miss refills the whole line from word-wide memory with a
// req/ack burst, one beat at a time, while stall is held to the fetch stage.
module icache_dm #(
   parameter int LINES  = 16,
   parameter int WORDS  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_req,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ready,
   output logic              stall,
   input  logic              flush,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int OB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TW = ADDR_W - OB - IB - 2;
   localparam logic [OB-1:0] LAST = {OB{1'b1}};

   typedef enum logic {IDLE, FILL} state_t;

   state_t              state;
   logic [LINES-1:0]    valid;
   logic [TW-1:0]       tag_mem  [LINES];
   logic [31:0]         data_mem [LINES][WORDS];
   logic [OB-1:0]       cnt;
   logic [TW-1:0]       fill_tag;
   logic [IB-1:0]       fill_idx;
   logic                flush_pend;

   // fetch address fields; the byte offset within a word is irrelevant
   logic [OB-1:0]       a_off;
   logic [IB-1:0]       a_idx;
   logic [TW-1:0]       a_tag;
   logic [OB-1:0]       cnt_nxt;
   logic                hit;
   logic                last_beat;
   logic                unused_ok;

   assign a_off     = cpu_addr[OB+1:2];
   assign a_idx     = cpu_addr[OB+IB+1:OB+2];
   assign a_tag     = cpu_addr[ADDR_W-1:OB+IB+2];
   assign unused_ok = ^cpu_addr[1:0];
   assign cnt_nxt   = cnt + 1'b1;
   assign last_beat = (cnt == LAST);

   // lookup only counts in IDLE; during a refill the line is in flux
   assign hit       = (state == IDLE) && valid[a_idx] && (tag_mem[a_idx] == a_tag);
   assign cpu_ready = cpu_req && hit;
   assign stall     = cpu_req && !cpu_ready;
   assign cpu_rdata = cpu_ready ? data_mem[a_idx][a_off] : 32'h0;

   // control FSM: miss detection, beat sequencing, valid bits and flush
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         valid      <= '0;
         cnt        <= '0;
         fill_tag   <= '0;
         fill_idx   <= '0;
         flush_pend <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               // flush wins over a miss: nothing is fetched that cycle
               if (flush) begin
                  valid <= '0;
               end else if (cpu_req && !hit) begin
                  fill_tag       <= a_tag;
                  fill_idx       <= a_idx;
                  valid[a_idx]   <= 1'b0;
                  cnt            <= '0;
                  mem_req        <= 1'b1;
                  mem_addr       <= {a_tag, a_idx, {OB{1'b0}}, 2'b00};
                  state          <= FILL;
               end
            end
            FILL: begin
               // a flush cannot abort the burst; remember it for the end
               if (flush) flush_pend <= 1'b1;
               if (mem_ack) begin
                  cnt <= cnt_nxt;
                  if (last_beat) begin
                     if (flush_pend || flush) valid <= '0;
                     else                     valid[fill_idx] <= 1'b1;
                     flush_pend <= 1'b0;
                     mem_req    <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     mem_addr <= {fill_tag, fill_idx, cnt_nxt, 2'b00};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // line storage; contents are meaningless until the valid bit says so
   always_ff @(posedge clk) begin
      if (state == FILL && mem_ack) begin
         data_mem[fill_idx][cnt] <= mem_rdata;
         if (last_beat) tag_mem[fill_idx] <= fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: refill bursts with a simple memory responder,
// a table of combinational lookups, and flush/reset corner sequences.
module tb_icache_dm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic        cpu_req;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic        req;
      logic        exp_ready;
      logic        exp_stall;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vt [9];

   icache_dm #(.LINES(16), .WORDS(4), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_req   (cpu_req),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .stall     (stall),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // serve one 4-beat refill; optionally pulse flush while a beat is pending
   task automatic fill_line(input logic [31:0] base, input logic [31:0] dbase, input int flush_beat);
      for (int b = 0; b < 4; b++) begin
         int t;
         t = 0;
         while (!mem_req && t < 20) begin
            @(negedge clk);
            t++;
         end
         chk("fill_req", {31'b0, mem_req}, 32'd1);
         chk("fill_addr", mem_addr, base + 32'(4 * b));
         chk("fill_stall", {31'b0, stall}, 32'd1);
         @(negedge clk);
         flush = (b == flush_beat);
         @(negedge clk);
         flush = 1'b0;
         chk("fill_hold", mem_addr, base + 32'(4 * b));
         mem_ack   = 1'b1;
         mem_rdata = dbase + 32'(b);
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 32'hDEAD_BEEF;
      end
      chk("fill_done_req", {31'b0, mem_req}, 32'd0);
   endtask

   initial begin
      vt[0] = '{32'h48,  1'b1, 1'b1, 1'b0, 32'hA2};
      vt[1] = '{32'h4C,  1'b1, 1'b1, 1'b0, 32'hA3};
      vt[2] = '{32'h40,  1'b1, 1'b1, 1'b0, 32'hA0};
      vt[3] = '{32'h43,  1'b1, 1'b1, 1'b0, 32'hA0};
      vt[4] = '{32'h86,  1'b1, 1'b1, 1'b0, 32'hC1};
      vt[5] = '{32'h8C,  1'b1, 1'b1, 1'b0, 32'hC3};
      vt[6] = '{32'h44,  1'b0, 1'b0, 1'b0, 32'h0};
      vt[7] = '{32'h140, 1'b1, 1'b0, 1'b1, 32'h0};
      vt[8] = '{32'h50,  1'b1, 1'b0, 1'b1, 32'h0};

      reset = 1'b1; cpu_addr = 32'h0; cpu_req = 1'b1; flush = 1'b0;
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rst_ready",   {31'b0, cpu_ready}, 32'd0);
      chk("rst_stall",   {31'b0, stall},     32'd1);
      chk("rst_mem_req", {31'b0, mem_req},   32'd0);
      chk("rst_mem_addr", mem_addr,          32'd0);
      chk("rst_rdata",   cpu_rdata,          32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // cold miss on 0x40
      cpu_addr = 32'h40;
      #1;
      chk("cold_stall", {31'b0, stall}, 32'd1);
      fill_line(32'h40, 32'hA0, -1);
      chk("cold_ready", {31'b0, cpu_ready}, 32'd1);
      chk("cold_rdata", cpu_rdata, 32'hA0);

      // second line at index 8
      @(negedge clk);
      cpu_addr = 32'h80;
      fill_line(32'h80, 32'hC0, -1);
      chk("l80_rdata", cpu_rdata, 32'hC0);

      // lookup table: each vector is withdrawn before the clock edge
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         cpu_addr = vt[i].addr;
         cpu_req  = vt[i].req;
         #1;
         chk($sformatf("vec%0d_ready", i), {31'b0, cpu_ready}, {31'b0, vt[i].exp_ready});
         chk($sformatf("vec%0d_stall", i), {31'b0, stall},     {31'b0, vt[i].exp_stall});
         chk($sformatf("vec%0d_rdata", i), cpu_rdata,          vt[i].exp_rdata);
         chk($sformatf("vec%0d_memreq", i), {31'b0, mem_req},  32'd0);
         #1;
         cpu_req = 1'b0;
      end

      // conflict: 0x140 evicts 0x40, then 0x40 misses again
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = 32'h140;
      fill_line(32'h140, 32'hB0, -1);
      chk("conf_rdata", cpu_rdata, 32'hB0);
      @(negedge clk);
      cpu_addr = 32'h40;
      #1;
      chk("conf_miss", {31'b0, stall}, 32'd1);
      fill_line(32'h40, 32'hA0, -1);
      chk("conf_rdata2", cpu_rdata, 32'hA0);

      // flush in IDLE
      @(negedge clk);
      cpu_req = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h44;
      #1;
      chk("flush_miss", {31'b0, cpu_ready}, 32'd0);
      fill_line(32'h40, 32'hD0, -1);
      chk("flush_rdata", cpu_rdata, 32'hD1);
      cpu_addr = 32'h80;
      #1;
      chk("flush_l80_gone", {31'b0, stall}, 32'd1);
      cpu_req = 1'b0;

      // flush during beat 2: burst completes, line stays invalid
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h40;
      fill_line(32'h40, 32'hE0, 2);
      chk("fpend_ready", {31'b0, cpu_ready}, 32'd0);
      chk("fpend_stall", {31'b0, stall},     32'd1);
      fill_line(32'h40, 32'hF0, -1);
      chk("fpend_rdata", cpu_rdata, 32'hF0);

      // reset during beat 1 of a 0x140 fill
      @(negedge clk);
      cpu_addr = 32'h140;
      begin
         int t;
         t = 0;
         while (!mem_req && t < 20) begin
            @(negedge clk);
            t++;
         end
      end
      chk("rmid_req0", {31'b0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h11;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("rmid_addr1", mem_addr, 32'h144);
      #2 reset = 1'b1;
      #1;
      chk("rmid_async_req",  {31'b0, mem_req}, 32'd0);
      chk("rmid_async_addr", mem_addr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cpu_addr = 32'h40;
      #1;
      chk("rmid_miss", {31'b0, stall}, 32'd1);
      fill_line(32'h40, 32'h70, -1);
      chk("rmid_rdata", cpu_rdata, 32'h70);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // hard stop so a wedged run still reports
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
